// File: rtl/frogger_game_ctrl.sv
// Game sequencing for the 16x16 Frogger playfield: idle/play/hit-flash/over FSM,
// lives and level tracking, and level-dependent traffic shift scheduling.
module frogger_game_ctrl #(
    parameter int unsigned TICK_DIV    = 1000000,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned FLASH_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic [3:0] frog_row,
    output logic       frog_en,
    output logic       frog_home,
    output logic       car_step,
    output logic       blank,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [1:0] state
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned FW = $clog2(FLASH_TICKS + 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StHit  = 2'b10,
        StOver = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] tick_cnt_q;
    logic [2:0]    step_q, step_d;
    logic [FW-1:0] flash_q, flash_d;
    logic [1:0]    lives_q, lives_d;
    logic [2:0]    level_q, level_d;
    logic          blank_q, blank_d;
    logic          frog_home_q, frog_home_d;
    logic          car_step_q, car_step_d;
    logic          frog_en_q, frog_en_d;
    logic          start_q, guard_q;

    logic tick, start_rise, guard, hit_ok, goal_ok, flash_done, step_match;

    assign tick       = (tick_cnt_q == CW'(TICK_DIV - 1));
    assign start_rise = start & ~start_q;
    // Masks the cycle of a frog_home pulse and the one after it.
    assign guard      = frog_home_q | guard_q;
    assign hit_ok     = hit & ~guard;
    assign goal_ok    = (frog_row == 4'd15) & ~hit_ok & ~guard;
    assign flash_done = tick & (flash_q == FW'(FLASH_TICKS - 1));
    assign step_match = (step_q == 3'd7 - level_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            step_q      <= '0;
            flash_q     <= '0;
            lives_q     <= 2'(LIVES);
            level_q     <= '0;
            blank_q     <= 1'b0;
            frog_home_q <= 1'b0;
            car_step_q  <= 1'b0;
            frog_en_q   <= 1'b0;
            // A start level held through reset must not look like a fresh press.
            start_q     <= 1'b1;
            guard_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;
            step_q      <= step_d;
            flash_q     <= flash_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            blank_q     <= blank_d;
            frog_home_q <= frog_home_d;
            car_step_q  <= car_step_d;
            frog_en_q   <= frog_en_d;
            start_q     <= start;
            guard_q     <= frog_home_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_rise) state_d = StPlay;
            StPlay: if (hit_ok) state_d = StHit;
            StHit:  if (flash_done) state_d = (lives_q == 2'd0) ? StOver : StPlay;
            StOver: if (start_rise) state_d = StPlay;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        step_d      = step_q;
        flash_d     = flash_q;
        blank_d     = 1'b0;
        lives_d     = lives_q;
        level_d     = level_q;
        frog_home_d = 1'b0;
        car_step_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                lives_d = 2'(LIVES);
                level_d = '0;
                if (start_rise) begin
                    frog_home_d = 1'b1;
                    step_d      = '0;
                end
            end
            StPlay: begin
                if (hit_ok) begin
                    lives_d = lives_q - 2'd1;
                    blank_d = 1'b1;
                    flash_d = '0;
                end else if (goal_ok) begin
                    level_d     = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
                    frog_home_d = 1'b1;
                    step_d      = '0;
                end else if (tick) begin
                    if (step_match) begin
                        car_step_d = 1'b1;
                        step_d     = '0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            StHit: begin
                blank_d = blank_q;
                if (flash_done) begin
                    blank_d     = 1'b0;
                    flash_d     = '0;
                    frog_home_d = (lives_q != 2'd0);
                    step_d      = '0;
                end else if (tick) begin
                    blank_d = ~blank_q;
                    flash_d = flash_q + 1'b1;
                end
            end
            StOver: begin
                lives_d = '0;
                if (start_rise) begin
                    lives_d     = 2'(LIVES);
                    level_d     = '0;
                    frog_home_d = 1'b1;
                    step_d      = '0;
                end
            end
            default: ;
        endcase
        frog_en_d = (state_d == StPlay);
    end

    assign frog_en   = frog_en_q;
    assign frog_home = frog_home_q;
    assign car_step  = car_step_q;
    assign blank     = blank_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign state     = state_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed bench for frogger_game_ctrl: expectations queued at drive time,
// popped and checked with immediate assertions once the DUT has clocked.
module tb_frogger_game_ctrl;

    typedef logic [31:0] word_t;

    logic       clk = 1'b0;
    logic       reset, start, hit;
    logic [3:0] frog_row;
    logic       frog_en, frog_home, car_step, blank;
    logic [1:0] lives, state;
    logic [2:0] level;

    int n_vec = 0;
    int n_bad = 0;

    word_t exp_q[$];
    string tag_q[$];

    frogger_game_ctrl #(
        .TICK_DIV   (4),
        .LIVES      (3),
        .FLASH_TICKS(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hit      (hit),
        .frog_row (frog_row),
        .frog_en  (frog_en),
        .frog_home(frog_home),
        .car_step (car_step),
        .blank    (blank),
        .lives    (lives),
        .level    (level),
        .state    (state)
    );

    always #5 clk = ~clk;

    function automatic word_t pk(input logic [1:0] st, input logic [1:0] lv,
                                 input logic [2:0] lvl, input logic fe, input logic fh,
                                 input logic cs, input logic bl);
        return {21'd0, st, lv, lvl, fe, fh, cs, bl};
    endfunction

    function automatic word_t outs();
        return {21'd0, state, lives, level, frog_en, frog_home, car_step, blank};
    endfunction

    task automatic push(input string t, input word_t v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_cmp(input word_t obs);
        string t;
        word_t e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_vec++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the next car_step pulse, capped at 100.
    task automatic measure_cs(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (car_step !== 1'b1 && n < 100);
    endtask

    task automatic wait_state_leave(input logic [1:0] s, output int n);
        n = 0;
        while (state === s && n < 40) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int cs_cnt;
        reset = 1'b1; start = 1'b0; hit = 1'b0; frog_row = 4'd0;
        repeat (3) cyc();
        push("reset_vals", pk(2'b00, 2'd3, 3'd0, 0, 0, 0, 0));
        pop_cmp(outs());
        reset = 1'b0;
        cyc(); cyc();

        // Start from IDLE
        start = 1'b1;
        push("start_enter", pk(2'b01, 2'd3, 3'd0, 1, 1, 0, 0));
        cyc(); pop_cmp(outs());
        push("start_home_1cyc", pk(2'b01, 2'd3, 3'd0, 1, 0, 0, 0));
        cyc(); pop_cmp(outs());

        // Level 0 car_step period
        measure_cs(n);
        push("cs_align_l0", 1);
        pop_cmp(word_t'(n < 100));
        push("cs_width", 0);
        cyc(); pop_cmp(word_t'(car_step));
        push("cs_interval_l0", 31);
        measure_cs(n); pop_cmp(n);

        // Single hit and flash
        hit = 1'b1;
        push("hit_enter", pk(2'b10, 2'd2, 3'd0, 0, 0, 0, 1));
        cyc(); pop_cmp(outs());
        hit = 1'b0;
        cs_cnt = 0;
        n = 0;
        while (blank === 1'b1 && n < 8) begin
            cyc(); n++;
            cs_cnt += int'(car_step);
        end
        push("flash_first_tick", 1);
        pop_cmp(word_t'(n >= 1 && n <= 4));
        push("flash_tick2", pk(2'b10, 2'd2, 3'd0, 0, 0, 0, 1));
        repeat (4) begin cyc(); cs_cnt += int'(car_step); end
        pop_cmp(outs());
        push("flash_tick3", pk(2'b10, 2'd2, 3'd0, 0, 0, 0, 0));
        repeat (4) begin cyc(); cs_cnt += int'(car_step); end
        pop_cmp(outs());
        push("flash_exit", pk(2'b01, 2'd2, 3'd0, 1, 1, 0, 0));
        repeat (4) cyc();
        pop_cmp(outs());
        push("no_cs_in_hit", 0);
        pop_cmp(cs_cnt);

        // Level progression and guard window
        cyc(); cyc();
        frog_row = 4'd15;
        push("goal_l1", pk(2'b01, 2'd2, 3'd1, 1, 1, 0, 0));
        cyc(); pop_cmp(outs());
        frog_row = 4'd0;
        hit = 1'b1;
        push("guard_a", pk(2'b01, 2'd2, 3'd1, 1, 0, 0, 0));
        cyc(); pop_cmp(outs());
        push("guard_b", pk(2'b01, 2'd2, 3'd1, 1, 0, 0, 0));
        cyc(); pop_cmp(outs());
        hit = 1'b0;
        measure_cs(n);
        cyc();
        push("cs_interval_l1", 27);
        measure_cs(n); pop_cmp(n);
        for (int l = 2; l <= 8; l++) begin
            frog_row = 4'd15;
            push($sformatf("goal_to_l%0d", l), {28'd0, (l > 7) ? 3'd7 : 3'(l), 1'b1});
            cyc(); pop_cmp({28'd0, level, frog_home});
            frog_row = 4'd0;
            cyc(); cyc();
        end
        measure_cs(n);
        cyc();
        push("cs_interval_l7", 3);
        measure_cs(n); pop_cmp(n);

        // Hit and goal together: hit wins, level unchanged
        cyc();
        hit = 1'b1; frog_row = 4'd15;
        push("hit_goal_same", pk(2'b10, 2'd1, 3'd7, 0, 0, 0, 1));
        cyc(); pop_cmp(outs());
        hit = 1'b0; frog_row = 4'd0;
        wait_state_leave(2'b10, n);
        push("hit2_exit", pk(2'b01, 2'd1, 3'd7, 1, 1, 0, 0));
        pop_cmp(outs());

        // Third hit -> game over
        cyc(); cyc();
        hit = 1'b1;
        push("hit3_enter", pk(2'b10, 2'd0, 3'd7, 0, 0, 0, 1));
        cyc(); pop_cmp(outs());
        hit = 1'b0;
        wait_state_leave(2'b10, n);
        push("game_over", pk(2'b11, 2'd0, 3'd7, 0, 0, 0, 0));
        pop_cmp(outs());
        cs_cnt = 0;
        repeat (40) begin cyc(); cs_cnt += int'(car_step); end
        push("over_hold", pk(2'b11, 2'd0, 3'd7, 0, 0, 0, 0));
        pop_cmp(outs());
        push("no_cs_in_over", 0);
        pop_cmp(cs_cnt);
        start = 1'b0;
        cyc();
        start = 1'b1;
        push("restart", pk(2'b01, 2'd3, 3'd0, 1, 1, 0, 0));
        cyc(); pop_cmp(outs());

        // Reset during HIT, with hit and start asserted
        cyc(); cyc();
        hit = 1'b1;
        push("hit_pre_reset", pk(2'b10, 2'd2, 3'd0, 0, 0, 0, 1));
        cyc(); pop_cmp(outs());
        hit = 1'b0;
        repeat (5) cyc();
        reset = 1'b1; hit = 1'b1;
        push("reset_in_hit", pk(2'b00, 2'd3, 3'd0, 0, 0, 0, 0));
        cyc(); pop_cmp(outs());
        cyc();
        reset = 1'b0; hit = 1'b0;

        // Start held high through reset must not start the game
        cs_cnt = 0;
        repeat (10) begin cyc(); cs_cnt += int'(car_step); end
        push("start_held_idle", pk(2'b00, 2'd3, 3'd0, 0, 0, 0, 0));
        pop_cmp(outs());
        push("no_cs_in_idle", 0);
        pop_cmp(cs_cnt);
        start = 1'b0;
        push("release_idle", pk(2'b00, 2'd3, 3'd0, 0, 0, 0, 0));
        cyc(); pop_cmp(outs());
        start = 1'b1;
        push("repress_start", pk(2'b01, 2'd3, 3'd0, 1, 1, 0, 0));
        cyc(); pop_cmp(outs());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
